// File: rtl/step3_pkg.sv
// step3_pkg: shared state, opcode and control-field encodings for the step3 control path.
package step3_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, EXEC, MEM_RD, MEM_WR, BRANCH, JUMP, WB, HALT
   } state_t;

   localparam logic [3:0] OP_ADDI = 4'h7;
   localparam logic [3:0] OP_LW   = 4'h8;
   localparam logic [3:0] OP_SW   = 4'h9;
   localparam logic [3:0] OP_BEQ  = 4'hA;
   localparam logic [3:0] OP_BLT  = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_LUI  = 4'hD;
   localparam logic [3:0] OP_NOP  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_CMP = 3'b111;

   localparam logic [2:0] RDW_ALU = 3'b000;
   localparam logic [2:0] RDW_MEM = 3'b001;
   localparam logic [2:0] RDW_IMM = 3'b010;

   localparam logic [1:0] CMP_EQ  = 2'b00;
   localparam logic [1:0] CMP_LT  = 2'b01;
   localparam logic [1:0] CMP_GT  = 2'b10;
   localparam logic [1:0] CMP_RSV = 2'b11;

   typedef struct packed {
      logic [1:0] num_bits;
      logic       ir_write;
      logic [1:0] imm_shift;
      logic       alu_src_a;
      logic       alu_src_b;
      logic [2:0] alu_op;
      logic       write_enable;
      logic       d_or_s;
      logic       mem_write;
      logic       mem_read;
      logic       mem_addr_sel;
      logic       pc_write;
      logic       pc_source;
      logic [2:0] reg_data_write;
      logic       halted;
   } ctrl_t;

   function automatic logic is_rtype(input logic [3:0] op);
      return op <= 4'h6;
   endfunction

   function automatic logic is_branch(input logic [3:0] op);
      return op == OP_BEQ || op == OP_BLT;
   endfunction

endpackage

// File: rtl/step3_ctrl_decode.sv
// step3_ctrl_decode: combinational Moore decode of state and latched opcode into control strobes.
module step3_ctrl_decode
   import step3_pkg::*;
(
   input  state_t      i_state,
   input  logic [3:0]  i_opq,
   input  logic [1:0]  i_cmp,
   output ctrl_t       o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      case (i_state)
         FETCH: begin
            o_ctrl.mem_read = 1'b1;
            o_ctrl.ir_write = 1'b1;
         end
         DECODE: begin
            o_ctrl.alu_op    = ALU_ADD;
            o_ctrl.alu_src_b = 1'b1;
            o_ctrl.imm_shift = 2'b01;
            o_ctrl.num_bits  = 2'b11;
            o_ctrl.pc_write  = 1'b1;
         end
         EXEC: begin
            if (is_rtype(i_opq)) begin
               o_ctrl.alu_src_a = 1'b1;
               o_ctrl.alu_op    = i_opq[2:0];
            end else if (is_branch(i_opq)) begin
               o_ctrl.alu_op = ALU_CMP;
               o_ctrl.d_or_s = 1'b1;
            end else begin
               o_ctrl.alu_src_b = 1'b1;
               o_ctrl.num_bits  = 2'b01;
            end
         end
         MEM_RD: begin
            o_ctrl.mem_addr_sel = 1'b1;
            o_ctrl.mem_read     = 1'b1;
         end
         MEM_WR: begin
            o_ctrl.mem_addr_sel = 1'b1;
            o_ctrl.mem_write    = 1'b1;
            o_ctrl.d_or_s       = 1'b1;
         end
         BRANCH: begin
            o_ctrl.pc_source = 1'b1;
            // reserved comparator code matches neither condition, so it never branches
            o_ctrl.pc_write  = (i_opq == OP_BEQ && i_cmp == CMP_EQ) ||
                               (i_opq == OP_BLT && i_cmp == CMP_LT);
         end
         JUMP: begin
            o_ctrl.pc_source = 1'b1;
            o_ctrl.pc_write  = 1'b1;
         end
         WB: begin
            o_ctrl.write_enable   = 1'b1;
            o_ctrl.reg_data_write = i_opq == OP_LW ? RDW_MEM : i_opq == OP_LUI ? RDW_IMM : RDW_ALU;
         end
         HALT: o_ctrl.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/step3_control.sv
// step3_control: multi-cycle control FSM for the step3 datapath; holds state, latched opcode
// and next-state logic, with strobes decoded in step3_ctrl_decode.
module step3_control
   import step3_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] op,
   input  logic [1:0] cmpRst,
   output logic [1:0] numBits,
   output logic       IRWrite,
   output logic [1:0] immShift,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       writeEnable,
   output logic       DOrS,
   output logic       memEnableWrite,
   output logic       memEnableRead,
   output logic       memAddrSel,
   output logic       PCWriteEnable,
   output logic       PCSource,
   output logic [2:0] regDataWrite,
   output logic       halted
);

   state_t     r_state;
   state_t     w_next;
   logic [3:0] r_opq;
   ctrl_t      w_ctrl;
   ctrl_t      w_out;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= FETCH;
         r_opq   <= 4'h0;
      end else begin
         r_state <= w_next;
         if (r_state == DECODE) r_opq <= op;
      end
   end

   always_comb begin
      w_next = FETCH;
      case (r_state)
         FETCH:  w_next = DECODE;
         DECODE: w_next = op == OP_JMP  ? JUMP :
                          op == OP_LUI  ? WB :
                          op == OP_NOP  ? FETCH :
                          op == OP_HALT ? HALT : EXEC;
         EXEC:   w_next = r_opq == OP_LW ? MEM_RD :
                          r_opq == OP_SW ? MEM_WR :
                          is_branch(r_opq) ? BRANCH : WB;
         MEM_RD: w_next = WB;
         HALT:   w_next = HALT;
         default: w_next = FETCH;
      endcase
   end

   step3_ctrl_decode u_decode (
      .i_state (r_state),
      .i_opq   (r_opq),
      .i_cmp   (cmpRst),
      .o_ctrl  (w_ctrl)
   );

   // reset blanks every strobe immediately, not just from the next edge
   assign w_out = RST ? '0 : w_ctrl;

   assign numBits        = w_out.num_bits;
   assign IRWrite        = w_out.ir_write;
   assign immShift       = w_out.imm_shift;
   assign ALUSrcA        = w_out.alu_src_a;
   assign ALUSrcB        = w_out.alu_src_b;
   assign ALUOp          = w_out.alu_op;
   assign writeEnable    = w_out.write_enable;
   assign DOrS           = w_out.d_or_s;
   assign memEnableWrite = w_out.mem_write;
   assign memEnableRead  = w_out.mem_read;
   assign memAddrSel     = w_out.mem_addr_sel;
   assign PCWriteEnable  = w_out.pc_write;
   assign PCSource       = w_out.pc_source;
   assign regDataWrite   = w_out.reg_data_write;
   assign halted         = w_out.halted;

endmodule
